mem_stage: RTL
==============

# mem_stage

Pipeline MEM stage of the 5-stage MIPS core: holds the EX/MEM pipeline register, drives a variable-latency data-memory port via a request/grant/rvalid handshake, and produces the MEM/WB register feeding RF write-back. It sits between the ALU/FWDPU (EX) and the RF write port (WB). It exports forwarding info to FWDPU and a stall request to HZDPU for the duration of outstanding memory accesses.

## Interface
Parameters:
- DW, 32, data/address width
- PCW, 9, width of pc_4 carried for jal link

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ex_valid  in  1  EX holds a real instruction (0 = bubble)
- ex_alu_res  in  DW  ALU result / memory byte address
- ex_wdata  in  DW  store data (forwarded rt)
- ex_wraddr  in  5  destination register
- ex_memread / ex_memwrite / ex_memtoreg / ex_regwrite / ex_link  in  1 each  controls from ID_EX
- ex_pc_4  in  PCW  return address for jal
- stall_req  out  1  freeze PC, IF_ID, ID_EX; EX/MEM does not load
- mem_regwrite  out  1  MEM-stage regwrite (to FWDPU)
- mem_wraddr  out  5  MEM-stage dest (to FWDPU)
- mem_memread  out  1  MEM-stage load flag (to FWDPU)
- dm_req  out  1  memory request
- dm_we  out  1  1 = write
- dm_addr  out  DW  word-aligned byte address
- dm_wdata  out  DW  write data
- dm_gnt  in  1  request accepted this cycle
- dm_rvalid  in  1  read data valid
- dm_rdata  in  DW  read data
- wb_regwrite  out  1  RF write enable
- wb_wraddr  out  5  RF write address
- wb_data  out  DW  RF write data
- misalign  out  1  one-cycle pulse: memory op with addr[1:0]!=0 suppressed

## Operation
- EX/MEM register loads all ex_* inputs on each rising edge with stall_req=0; bubble (ex_valid=0) loads with all controls 0.
- FSM states: IDLE, REQ, WAIT.
- IDLE: a memory op (memread|memwrite) loaded into EX/MEM with addr[1:0]==0 -> REQ. Misaligned op: stays IDLE, misalign pulses in the cycle after load, regwrite and memwrite forced 0, instruction retires as bubble.
- REQ: dm_req=1, dm_we=memwrite, dm_addr/dm_wdata from EX/MEM, stable until dm_gnt. On dm_gnt: write -> IDLE (complete); read -> WAIT.
- WAIT: dm_req=0; on dm_rvalid capture dm_rdata, -> IDLE.
- dm_rvalid outside WAIT is ignored; dm_gnt outside REQ is ignored.
- stall_req = (REQ & ~(dm_gnt & dm_we)) | (WAIT & ~dm_rvalid).
- MEM/WB loads when the MEM instruction completes (non-memory op: immediately; write: gnt; read: rvalid); otherwise loads a bubble (wb_regwrite=0).
- wb_data = memtoreg ? dm_rdata : link ? zero-extended pc_4 : alu_res.
- mem_regwrite/mem_wraddr/mem_memread reflect the EX/MEM register contents directly.

## Timing
- Reset: all registers, state=IDLE, every output 0; asserting rst mid-access drops dm_req asynchronously; a later dm_rvalid is ignored.
- Non-memory op: in MEM 1 cycle, WB outputs valid the next cycle.
- Write with same-cycle gnt: zero stall. Each cycle without gnt adds one stall.
- Read: minimum one stall cycle (REQ then WAIT with rvalid); wb_data valid the cycle after rvalid.
- Back-to-back memory ops: the next op enters EX/MEM on the completing edge; REQ re-entered with no idle cycle.

## Structure
- Shared package mips_pkg: DW, PCW, FSM state enum (IDLE/REQ/WAIT), register-address width 5.
- One sub-module dm_if_fsm: state register, dm_* drive, stall_req, completion strobe. Pipeline registers and wb_data mux stay in mem_stage.

## Test plan
- add result 0x0000_0010 to r8, no memory -> wb_regwrite=1, wb_wraddr=8, wb_data=0x10 one cycle later, stall_req never 1.
- sw 0xDEAD_BEEF to 0x40, gnt same cycle -> dm_req=1, dm_we=1, dm_addr=0x40, stall_req=0, wb_regwrite=0.
- lw from 0x80, gnt after 2 cycles, rvalid 3 cycles after gnt, rdata 0x1234_5678 -> stall_req=1 for 5 cycles, then wb_data=0x1234_5678.
- lw to 0x42 -> no dm_req, misalign pulses once, wb_regwrite=0.
- jal with pc_4=0x01C -> wb_wraddr=31, wb_data=0x0000_001C.
- rst raised while in WAIT, rvalid arrives afterwards -> all outputs 0, state IDLE, no write-back.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline stages: datapath widths,
// data-memory interface FSM states and a small address helper.
package mips_pkg;

    localparam int unsigned DW  = 32;  // data / address width
    localparam int unsigned PCW = 9;   // width of pc_4 carried for jal link
    localparam int unsigned RAW = 5;   // register-file address width

    // Data-memory handshake states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } dm_state_e;

    // True when the two low byte-address bits select a word boundary
    function automatic logic word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/dm_if_fsm.sv
// Data-memory port sequencer for the MEM stage.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   start       - an aligned memory op is entering EX/MEM (sampled on completing edges)
//   write       - EX/MEM holds a store
//   dm_gnt      - memory accepted the request this cycle
//   dm_rvalid   - read data valid this cycle
//   dm_req      - request strobe (registered)
//   dm_we       - write qualifier of the request
//   stall_req   - MEM instruction has not completed this cycle
//   complete    - MEM instruction completes on the coming edge
module dm_if_fsm
    import mips_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic write,
    input  logic dm_gnt,
    input  logic dm_rvalid,
    output logic dm_req,
    output logic dm_we,
    output logic stall_req,
    output logic complete
);

    dm_state_e state;
    logic      req_q;

    // State and request register; a completing edge may start the next op directly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            req_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= REQ;
                        req_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (dm_gnt) begin
                        if (write) begin
                            state <= start ? REQ : IDLE;
                            req_q <= start;
                        end else begin
                            state <= WAIT;
                            req_q <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (dm_rvalid) begin
                        state <= start ? REQ : IDLE;
                        req_q <= start;
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    assign dm_req = req_q;
    assign dm_we  = req_q & write;

    // A granted store finishes in the same cycle, a read finishes on rvalid
    assign stall_req = ((state == REQ)  & ~(dm_gnt & dm_we)) |
                       ((state == WAIT) & ~dm_rvalid);
    assign complete  = ~stall_req;

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS core: EX/MEM register, data-memory
// handshake, MEM/WB register and write-back data select.
// Ports:
//   clk, rst                       - clock, asynchronous active-high reset
//   ex_*                           - instruction arriving from EX (ex_valid=0 is a bubble)
//   stall_req                      - hold upstream stages; EX/MEM does not load
//   mem_regwrite/wraddr/memread    - EX/MEM contents for forwarding
//   dm_req/we/addr/wdata           - data-memory request
//   dm_gnt/rvalid/rdata            - data-memory response
//   wb_regwrite/wraddr/data        - register-file write port
//   misalign                       - one-cycle pulse for a suppressed misaligned op
module mem_stage #(
    parameter int unsigned DW  = mips_pkg::DW,
    parameter int unsigned PCW = mips_pkg::PCW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ex_valid,
    input  logic [DW-1:0]            ex_alu_res,
    input  logic [DW-1:0]            ex_wdata,
    input  logic [mips_pkg::RAW-1:0] ex_wraddr,
    input  logic                     ex_memread,
    input  logic                     ex_memwrite,
    input  logic                     ex_memtoreg,
    input  logic                     ex_regwrite,
    input  logic                     ex_link,
    input  logic [PCW-1:0]           ex_pc_4,
    output logic                     stall_req,
    output logic                     mem_regwrite,
    output logic [mips_pkg::RAW-1:0] mem_wraddr,
    output logic                     mem_memread,
    output logic                     dm_req,
    output logic                     dm_we,
    output logic [DW-1:0]            dm_addr,
    output logic [DW-1:0]            dm_wdata,
    input  logic                     dm_gnt,
    input  logic                     dm_rvalid,
    input  logic [DW-1:0]            dm_rdata,
    output logic                     wb_regwrite,
    output logic [mips_pkg::RAW-1:0] wb_wraddr,
    output logic [DW-1:0]            wb_data,
    output logic                     misalign
);
    import mips_pkg::*;

    // EX/MEM register
    logic [DW-1:0]  q_alu;
    logic [DW-1:0]  q_wdata;
    logic [RAW-1:0] q_wraddr;
    logic           q_memread;
    logic           q_memwrite;
    logic           q_memtoreg;
    logic           q_regwrite;
    logic           q_link;
    logic [PCW-1:0] q_pc_4;

    logic complete;
    logic ex_memop;
    logic ex_misal;
    logic start;

    assign ex_memop = ex_valid & (ex_memread | ex_memwrite);
    assign ex_misal = ex_memop & ~word_aligned(ex_alu_res[1:0]);
    assign start    = ex_memop & ~ex_misal;

    // EX/MEM loads whenever the current MEM instruction completes;
    // a misaligned op keeps travelling but can neither write memory nor the RF
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_alu      <= '0;
            q_wdata    <= '0;
            q_wraddr   <= '0;
            q_memread  <= 1'b0;
            q_memwrite <= 1'b0;
            q_memtoreg <= 1'b0;
            q_regwrite <= 1'b0;
            q_link     <= 1'b0;
            q_pc_4     <= '0;
            misalign   <= 1'b0;
        end else begin
            misalign <= complete & ex_misal;
            if (complete) begin
                q_alu      <= ex_alu_res;
                q_wdata    <= ex_wdata;
                q_wraddr   <= ex_wraddr;
                q_pc_4     <= ex_pc_4;
                q_memread  <= ex_valid & ex_memread;
                q_memwrite <= ex_valid & ex_memwrite & ~ex_misal;
                q_memtoreg <= ex_valid & ex_memtoreg;
                q_regwrite <= ex_valid & ex_regwrite & ~ex_misal;
                q_link     <= ex_valid & ex_link;
            end
        end
    end

    dm_if_fsm u_dm_if_fsm (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .write     (q_memwrite),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .stall_req (stall_req),
        .complete  (complete)
    );

    assign dm_addr      = {q_alu[DW-1:2], 2'b00};
    assign dm_wdata     = q_wdata;
    assign mem_regwrite = q_regwrite;
    assign mem_wraddr   = q_wraddr;
    assign mem_memread  = q_memread;

    // MEM/WB register: retire the completing instruction, else insert a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_regwrite <= 1'b0;
            wb_wraddr   <= '0;
            wb_data     <= '0;
        end else if (complete) begin
            wb_regwrite <= q_regwrite;
            wb_wraddr   <= q_wraddr;
            wb_data     <= q_memtoreg ? dm_rdata :
                           q_link     ? DW'(q_pc_4) : q_alu;
        end else begin
            wb_regwrite <= 1'b0;
            wb_wraddr   <= '0;
            wb_data     <= '0;
        end
    end

endmodule
